demux32_collector: RTL and testbench

//   Serial-to-parallel counterpart of the 32:1 mux: steers a stream of single bits

---
 rtl/demux32_collector.sv | 64 ++++++
 tb/tb_demux32_collector.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/demux32_collector.sv
// demux32_collector: bit-serial to parallel collector with flush and valid/ready word output
module demux32_collector #(
    parameter int N     = 32,
    parameter int SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_bit_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             flush_i,
    output logic [SEL_W-1:0] sel_o,
    output logic [N-1:0]     out_word_o,
    output logic [SEL_W:0]   out_count_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
);
    typedef enum logic {FILL, FULL} state_t;

    state_t           state_q;
    logic [SEL_W-1:0] sel_q;
    logic [N-1:0]     word_q;
    logic [SEL_W:0]   count_q;

    // Collect bits into word_q at sel_q; close on the N-th bit or on flush, then hold until taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            sel_q   <= '0;
            word_q  <= '0;
            count_q <= '0;
        end else if (state_q == FILL) begin
            if (in_valid_i) begin
                word_q[sel_q] <= in_bit_i;
                if (sel_q == SEL_W'(N - 1)) begin
                    sel_q   <= '0;
                    count_q <= (SEL_W + 1)'(N);
                    state_q <= FULL;
                end else if (flush_i) begin
                    sel_q   <= '0;
                    count_q <= {1'b0, sel_q} + 1'b1;
                    state_q <= FULL;
                end else begin
                    sel_q <= sel_q + 1'b1;
                end
            end else if (flush_i && sel_q != '0) begin
                sel_q   <= '0;
                count_q <= {1'b0, sel_q};
                state_q <= FULL;
            end
        end else if (out_ready_i) begin
            sel_q   <= '0;
            word_q  <= '0;
            count_q <= '0;
            state_q <= FILL;
        end
    end

    assign in_ready_o  = (state_q == FILL);
    assign out_valid_o = (state_q == FULL);
    assign sel_o       = sel_q;
    assign out_word_o  = word_q;
    assign out_count_o = count_q;
endmodule

// File: tb/tb_demux32_collector.sv
// tb_demux32_collector: directed and random scoreboard bench for demux32_collector
module tb_demux32_collector;
    localparam int N = 32;

    logic        clk = 0;
    logic        rst = 1;
    logic        in_bit_i = 0;
    logic        in_valid_i = 0;
    logic        flush_i = 0;
    logic        out_ready_i = 0;
    logic        in_ready_o;
    logic [4:0]  sel_o;
    logic [31:0] out_word_o;
    logic [5:0]  out_count_o;
    logic        out_valid_o;

    demux32_collector dut (
        .clk(clk), .rst(rst), .in_bit_i(in_bit_i), .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o), .flush_i(flush_i), .sel_o(sel_o),
        .out_word_o(out_word_o), .out_count_o(out_count_o),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i)
    );

    always #5 clk = ~clk;

    int total = 0, passed = 0, valid_cycles = 0, words_pushed = 0;
    logic [37:0] sb[$];
    logic [31:0] mw = 0;
    int mc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic push_word();
        sb.push_back({6'(mc), mw});
        words_pushed++;
        mw = 0;
        mc = 0;
    endtask

    // one clock of stimulus; the model mirrors the behavioural rules on what was accepted
    task automatic step(input logic v, input logic b, input logic f, input logic r, output logic acc);
        in_valid_i  = v;
        in_bit_i    = b;
        flush_i     = f;
        out_ready_i = r;
        acc = in_ready_o;
        @(posedge clk);
        if (acc && v) begin
            mw[mc] = b;
            mc++;
            if (mc == N || f) push_word();
        end else if (acc && f && mc > 0) push_word();
        #1;
        in_valid_i = 0;
        flush_i    = 0;
    endtask

    task automatic idle(input logic f, input logic r);
        logic a;
        step(0, 0, f, r, a);
    endtask

    task automatic send(input logic b, input logic r);
        logic a;
        int n = 0;
        do begin
            step(1, b, 0, r, a);
            n++;
        end while (!a && n < 100);
        chk("send_timeout", a, 1);
    endtask

    task automatic send_word(input logic [31:0] w, input logic r);
        for (int k = 0; k < N; k++) send(w[k], r);
    endtask

    // monitor: every handshake must match the oldest expected word
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid_o) valid_cycles++;
            if (!rst && out_valid_o && out_ready_i) begin
                if (sb.size() == 0) chk("extra_word", sb.size(), 1);
                else begin
                    logic [37:0] e;
                    e = sb.pop_front();
                    chk("sb_word", out_word_o, e[31:0]);
                    chk("sb_count", out_count_o, e[37:32]);
                end
            end
        end
    end

    initial begin
        #900us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic a;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("rst_valid", out_valid_o, 0);
        chk("rst_ready", in_ready_o, 1);
        chk("rst_count", out_count_o, 0);
        // reset in the middle of a word
        for (int k = 0; k < 7; k++) send(k[0], 1);
        chk("mid_sel", sel_o, 7);
        rst = 1;
        #1;
        chk("arst_sel", sel_o, 0);
        chk("arst_word", out_word_o, 0);
        chk("arst_valid", out_valid_o, 0);
        chk("arst_ready", in_ready_o, 1);
        @(posedge clk);
        #1 rst = 0;
        mw = 0;
        mc = 0;
        // one-hot sweep with the consumer always ready
        valid_cycles = 0;
        for (int j = 0; j < N; j++) send_word(32'(1) << j, 1);
        idle(0, 1);
        idle(0, 1);
        chk("onehot_valid_cycles", valid_cycles, 32);
        chk("onehot_drained", sb.size(), 0);
        // back-pressure: word held, extra bits refused
        send_word(32'hDEADBEEF, 0);
        for (int k = 0; k < 5; k++) begin
            step(1, 1, 0, 0, a);
            chk("bp_word", out_word_o, 32'hDEADBEEF);
            chk("bp_count", out_count_o, 32);
            chk("bp_in_ready", in_ready_o, 0);
            chk("bp_valid", out_valid_o, 1);
        end
        idle(0, 1);
        chk("bp_sel_after", sel_o, 0);
        chk("bp_ready_after", in_ready_o, 1);
        // flush after five bits
        send(1, 0); send(0, 0); send(1, 0); send(1, 0); send(0, 0);
        chk("fl_sel", sel_o, 5);
        idle(1, 0);
        chk("fl_valid", out_valid_o, 1);
        chk("fl_word", out_word_o, 32'h0000000D);
        chk("fl_count", out_count_o, 5);
        idle(0, 1);
        // flush together with a sixth bit
        send(1, 0); send(0, 0); send(1, 0); send(1, 0); send(0, 0);
        step(1, 1, 1, 0, a);
        chk("flb_word", out_word_o, 32'h0000002D);
        chk("flb_count", out_count_o, 6);
        idle(0, 1);
        // flush with nothing collected is ignored
        idle(1, 1);
        chk("fl0_valid", out_valid_o, 0);
        chk("fl0_sel", sel_o, 0);
        // flush while FULL is ignored
        send_word(32'hA5A50F0F, 0);
        idle(1, 0);
        chk("flfull_word", out_word_o, 32'hA5A50F0F);
        chk("flfull_count", out_count_o, 32);
        chk("flfull_valid", out_valid_o, 1);
        idle(0, 1);
        // random traffic
        words_pushed = 0;
        while (words_pushed < 1000) begin
            step($urandom_range(3) != 0, 1'($urandom), $urandom_range(63) == 0,
                 $urandom_range(1) == 1, a);
        end
        repeat (4) idle(0, 1);
        chk("final_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
